// File: rtl/ray_dispatcher_if.sv
// Frame-buffer write port between ray_dispatcher (master) and the frame RAM (slave).
interface ray_dispatcher_if #(
  parameter int ADDR_W = 15
);
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;
  logic              fb_ready;

  modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/ray_dispatcher.sv
// Frame scanner for ray_tracer: issues one ray per pixel, samples the colour after HOLD
// cycles and writes it to the frame buffer over a ready/valid port.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | dir presented for current pixel, counting hold cycles
// WRITE | colour captured, fb_we high until fb_ready
// DONE  | one-cycle end-of-frame, done high
module ray_dispatcher #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int HOLD   = 4,
  parameter int FOCAL  = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [27:0]         cam_pos,
  input  logic [11:0]         tracer_dout,
  input  logic                tracer_collision,
  output logic [27:0]         init,
  output logic [30:0]         dir,
  ray_dispatcher_if.master    fb,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   hit_count
);
  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [HW-1:0]     hold;
  logic [ADDR_W-1:0] pix;
  logic              coll;
  logic              take_start, sample, accept, advance;
  logic              wrap, last;

  function automatic logic [30:0] dir_of(input logic [CW-1:0] c, input logic [RW-1:0] r);
    logic [9:0] dx;
    logic [9:0] dy;
    dx = 10'(c) - 10'(H_RES / 2);
    dy = 10'(V_RES / 2) - 10'(r);
    return {11'(FOCAL), dy, dx};
  endfunction

  assign wrap    = (col == CW'(H_RES - 1));
  assign last    = wrap && (row == RW'(V_RES - 1));
  assign col_nxt = wrap ? '0 : col + 1'b1;
  assign row_nxt = wrap ? row + 1'b1 : row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    sample     = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold == HW'(HOLD - 1)) begin
          sample    = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb.fb_ready) begin
          accept = 1'b1;
          if (last) state_nxt = S_DONE;
          else begin
            advance   = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
    endcase
  end

  // pix tracks row*H_RES + col incrementally, so no multiplier is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      pix        <= '0;
      coll       <= 1'b0;
      init       <= '0;
      dir        <= '0;
      fb.fb_we   <= 1'b0;
      fb.fb_addr <= '0;
      fb.fb_data <= '0;
      hit_count  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);
      if (state == S_DONE) busy <= 1'b0;
      if (state == S_ISSUE) hold <= hold + 1'b1;
      if (take_start) begin
        col       <= '0;
        row       <= '0;
        hold      <= '0;
        pix       <= '0;
        init      <= cam_pos;
        hit_count <= '0;
        busy      <= 1'b1;
        dir       <= dir_of('0, '0);
      end
      if (sample) begin
        fb.fb_data <= tracer_dout;
        fb.fb_addr <= pix;
        fb.fb_we   <= 1'b1;
        coll       <= tracer_collision;
      end
      if (accept) begin
        fb.fb_we <= 1'b0;
        if (coll) hit_count <= hit_count + 1'b1;
      end
      if (advance) begin
        col  <= col_nxt;
        row  <= row_nxt;
        pix  <= pix + 1'b1;
        hold <= '0;
        dir  <= dir_of(col_nxt, row_nxt);
      end
    end
  end
endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher on a 4x2 frame: pixel-level reference model plus literal timing checks.
module tb_ray_dispatcher;
  localparam int H = 4, V = 2, HOLD = 4, AW = 15, N = H * V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [27:0]   cam_pos = 28'h1234567;
  logic [11:0]   tracer_dout;
  logic          tracer_collision;
  logic [27:0]   init;
  logic [30:0]   dir;
  logic          busy, done;
  logic [AW-1:0] hit_count;

  ray_dispatcher_if #(.ADDR_W(AW)) fb_if ();

  ray_dispatcher #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .HOLD(HOLD), .FOCAL(200)) dut (
    .clk(clk), .rst(rst_n), .start(start), .cam_pos(cam_pos),
    .tracer_dout(tracer_dout), .tracer_collision(tracer_collision),
    .init(init), .dir(dir), .fb(fb_if), .busy(busy), .done(done), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Stand-in tracer: decodes the pixel from dir; even pixels white, collisions on pixels 1 and 6.
  int t_pix;
  always_comb begin
    t_pix = (V / 2 - int'($signed(dir[19:10]))) * H + int'($signed(dir[9:0])) + H / 2;
    tracer_dout = (t_pix % 2 == 0) ? 12'hFFF : 12'h000;
    tracer_collision = (t_pix == 1) || (t_pix == 6);
  end

  function automatic logic [30:0] exp_dir(input int p);
    logic [9:0] dx, dy;
    dx = 10'((p % H) - H / 2);
    dy = 10'(V / 2 - p / H);
    return {11'd200, dy, dx};
  endfunction

  // Pixel-level model: each pixel spends HOLD cycles issuing, then waits in write until accepted.
  logic        m_busy = 0, m_done = 0, m_we = 0;
  int          m_pix = 0, m_t = 0, m_hits = 0, m_addr = 0;
  logic [11:0] m_data = 0;
  logic [27:0] m_init = 0;
  logic [30:0] m_dir = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_we = 0; m_pix = 0; m_t = 0; m_hits = 0;
      m_addr = 0; m_data = 0; m_init = 0; m_dir = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_pix = 0; m_t = 0; m_hits = 0;
        m_init = cam_pos;
        m_dir  = exp_dir(0);
      end
    end else if (m_we) begin
      if (fb_if.fb_ready) begin
        m_we = 0;
        if (m_pix == 1 || m_pix == 6) m_hits++;
        if (m_pix == N - 1) m_done = 1;
        else begin
          m_pix++;
          m_t = 0;
          m_dir = exp_dir(m_pix);
        end
      end
    end else begin
      m_t++;
      if (m_t == HOLD) begin
        m_we = 1;
        m_addr = m_pix;
        m_data = (m_pix % 2 == 0) ? 12'hFFF : 12'h000;
      end
    end
  end

  // Compare process: also owns fb_ready (stall injection) and the event logs.
  int          ncyc = 0;
  int          stall_arm = 0, stall_cnt = 0;
  logic        prev_busy = 0;
  int          acc_cyc[$], acc_addr[$], done_q[$], fall_q[$];
  logic [11:0] acc_data[$];
  logic [30:0] acc_dir[$];

  always @(negedge clk) begin
    ncyc++;
    if (fb_if.fb_we && fb_if.fb_addr == AW'(2) && stall_cnt < stall_arm) begin
      fb_if.fb_ready = 1'b0;
      stall_cnt++;
    end else fb_if.fb_ready = 1'b1;
    if (!busy) stall_cnt = 0;
    chk("fb_we", fb_if.fb_we, m_we);
    chk("fb_addr", fb_if.fb_addr, AW'(m_addr));
    chk("fb_data", fb_if.fb_data, m_data);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("hit_count", hit_count, AW'(m_hits));
    chk("init", init, m_init);
    chk("dir", dir, m_dir);
    if (fb_if.fb_we && fb_if.fb_ready) begin
      acc_cyc.push_back(ncyc);
      acc_addr.push_back(int'(fb_if.fb_addr));
      acc_data.push_back(fb_if.fb_data);
      acc_dir.push_back(dir);
    end
    if (done) done_q.push_back(ncyc);
    if (prev_busy && !busy) fall_q.push_back(ncyc);
    prev_busy = busy;
  end

  int base, qa, db, fbq;

  task start_frame();
    @(negedge clk); #1;
    base = ncyc;
    qa   = acc_cyc.size();
    db   = done_q.size();
    fbq  = fall_q.size();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task wait_idle(input bit poke_done);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (fall_q.size() > fbq) return;
      if (poke_done && done) begin
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL frame_timeout: busy still %0b, required 0 within 400 cycles", busy);
  endtask

  task automatic chk_acc(input int i, input int e_edge, input int e_addr);
    if (acc_cyc.size() <= qa + i) begin
      n_checks++; n_fail++;
      $display("FAIL acc%0d: got %0d writes, required at least %0d", i, acc_cyc.size() - qa, i + 1);
    end else begin
      chk($sformatf("acc%0d_edge", i), 64'(acc_cyc[qa+i] - base), 64'(e_edge));
      chk($sformatf("acc%0d_addr", i), 64'(acc_addr[qa+i]), 64'(e_addr));
      chk($sformatf("acc%0d_data", i), 64'(acc_data[qa+i]), (i % 2 == 0) ? 64'hFFF : 64'h0);
    end
  endtask

  task automatic chk_frame_end(input string tag, input int e_done, input int e_fall);
    if (done_q.size() != db + 1 || fall_q.size() <= fbq) begin
      n_checks++; n_fail++;
      $display("FAIL %s_end: got %0d done pulses, required 1", tag, done_q.size() - db);
    end else begin
      chk({tag, "_done_edge"}, 64'(done_q[db] - base - 1), 64'(e_done));
      chk({tag, "_busy_fall"}, 64'(fall_q[fbq] - base - 1), 64'(e_fall));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fb_we", fb_if.fb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dir", dir, 0);
    chk("rst_hit", hit_count, 0);
    rst_n = 1'b1;

    // Frame A: no stalls; stray start and cam_pos change mid-frame must be ignored.
    start_frame();
    repeat (18) @(negedge clk);
    #1;
    start = 1'b1;
    cam_pos = 28'hABCDEF0;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle(1'b0);
    chk("a_writes", acc_cyc.size() - qa, 8);
    for (int i = 0; i < 8; i++) chk_acc(i, 5 * (i + 1), i);
    if (acc_dir.size() >= qa + 8) begin
      chk("a_dir_pix0", acc_dir[qa], {11'd200, 10'd1, 10'h3FE});
      chk("a_dir_pix7", acc_dir[qa+7], {11'd200, 10'd0, 10'd1});
    end
    chk_frame_end("a", 40, 41);
    chk("a_hits", hit_count, 2);
    chk("a_init", init, 28'h1234567);

    // Frame B: three stall cycles on pixel 2; start during DONE ignored.
    stall_arm = 3;
    start_frame();
    chk("b_hit_clear", hit_count, 0);
    wait_idle(1'b1);
    chk_acc(1, 10, 1);
    chk_acc(2, 18, 2);
    chk_acc(3, 23, 3);
    chk_acc(7, 43, 7);
    chk_frame_end("b", 43, 44);
    chk("b_hits", hit_count, 2);
    chk("b_init", init, 28'hABCDEF0);
    repeat (3) @(negedge clk);
    #1;
    chk("b_idle_after_done", busy, 0);

    // Frame C: reset during pixel 4's write.
    stall_arm = 0;
    start_frame();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (fb_if.fb_we && fb_if.fb_addr == AW'(4)) break;
    end
    chk("c_hit_before_rst", hit_count, 1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_fb_we", fb_if.fb_we, 0);
    chk("c_rst_busy", busy, 0);
    chk("c_rst_hit", hit_count, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Frame D: clean restart from address 0.
    start_frame();
    wait_idle(1'b0);
    chk("d_writes", acc_cyc.size() - qa, 8);
    chk_acc(0, 5, 0);
    chk_acc(7, 40, 7);
    chk_frame_end("d", 40, 41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
